// File: rtl/sr_bank_driver_if.sv
// Handshake and cell-drive bundle between a word source and the SR bank driver.
interface sr_bank_driver_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] s_out;
    logic [WIDTH-1:0] r_out;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] state_q;

    modport master (
        output in_valid, in_data,
        input  in_ready, s_out, r_out, busy, done, state_q
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, s_out, r_out, busy, done, state_q
    );
endinterface

// File: rtl/sr_bank_driver.sv
// Diffs a target word against a shadow of the SR bank and pulses S or R one cell at a time.
// SR_BANK_INIT_CLEAR_EN: after reset, pulse every R line once so the bank matches the cleared shadow.
module sr_bank_driver #(
    parameter int WIDTH     = 8,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic            clk,
    input  logic            rst,
    sr_bank_driver_if.slave bus
);
    localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(WIDTH - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, SCAN, PULSE, GAP, DONE
`ifdef SR_BANK_INIT_CLEAR_EN
        , INIT_PULSE, INIT_GAP
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] cell_sel;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sel
        assign cell_sel[gi] = (idx_q == IW'(gi));
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && ready_q) begin
                    target_d = bus.in_data;
                    idx_d    = '0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (target_q[idx_q] != shadow_q[idx_q]) begin
                    cnt_d   = '0;
                    state_d = PULSE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            PULSE: begin
                // Shadow follows the cell only once its pulse has run to completion.
                if (cnt_q == PULSE_LAST) begin
                    shadow_d[idx_q] = target_q[idx_q];
                    cnt_d           = '0;
                    state_d         = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SCAN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
`ifdef SR_BANK_INIT_CLEAR_EN
            INIT_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = INIT_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            INIT_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered without lag.
        s_d = '0;
        r_d = '0;
        if (state_d == PULSE) begin
            if (target_q[idx_q]) s_d = cell_sel;
            else                 r_d = cell_sel;
        end
`ifdef SR_BANK_INIT_CLEAR_EN
        if (state_d == INIT_PULSE) r_d = '1;
`endif
        done_d  = (state_d == DONE);
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target_q <= '0;
            shadow_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            s_q      <= '0;
            done_q   <= 1'b0;
`ifdef SR_BANK_INIT_CLEAR_EN
            state_q  <= INIT_PULSE;
            r_q      <= '1;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
`else
            state_q  <= IDLE;
            r_q      <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            r_q      <= r_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.in_ready = ready_q;
    assign bus.s_out    = s_q;
    assign bus.r_out    = r_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.state_q  = shadow_q;
endmodule

// File: tb/tb_sr_bank_driver.sv
// Directed bench for sr_bank_driver (WIDTH=4, PULSE_CYC=2, GAP_CYC=1); cycle n = n-th cycle after the transfer edge.
module tb_sr_bank_driver;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sr_bank_driver_if #(.WIDTH(W)) bus ();

    sr_bank_driver #(.WIDTH(W), .PULSE_CYC(2), .GAP_CYC(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] s_hist [64];
    logic [W-1:0] r_hist [64];
    logic [W-1:0] st_hist [64];
    logic         rdy_hist [64];
    logic         busy_hist [64];
    logic         done_hist [64];
    logic [W-1:0] s_or, r_or;
    int           done_at;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic record(input int n);
        s_hist[n]    = bus.s_out;
        r_hist[n]    = bus.r_out;
        st_hist[n]   = bus.state_q;
        rdy_hist[n]  = bus.in_ready;
        busy_hist[n] = bus.busy;
        done_hist[n] = bus.done;
        s_or |= bus.s_out;
        r_or |= bus.r_out;
        if (bus.done === 1'b1 && done_at == 0) done_at = n;
    endtask

    // Offers one word, then records one sample per cycle until the cycle after done.
    // hold keeps in_valid high with changing data while busy; abort_at raises rst after that cycle.
    task automatic run_word(input logic [W-1:0] data, input bit hold, input int abort_at);
        int guard;
        int n;
        for (int i = 0; i < 64; i++) begin
            s_hist[i] = '0; r_hist[i] = '0; st_hist[i] = '0;
            rdy_hist[i] = 1'b0; busy_hist[i] = 1'b0; done_hist[i] = 1'b0;
        end
        s_or = '0;
        r_or = '0;
        done_at = 0;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_write", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        @(posedge clk);
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            record(n);
            if (hold && done_at == 0) begin
                bus.in_valid = 1'b1;
                bus.in_data  = W'(n * 5 + 3);
            end else begin
                bus.in_valid = 1'b0;
            end
            if (abort_at != 0 && n == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                n++;
                record(n);
                rst = 1'b0;
                return;
            end
            if (done_at != 0 && n == done_at + 1) break;
        end
        bus.in_valid = 1'b0;
        check("done_seen", 32'(done_at != 0), 1);
        if (done_at != 0) begin
            check("done_one_cycle", 32'(done_hist[done_at + 1]), 0);
            check("ready_low_at_done", 32'(rdy_hist[done_at]), 0);
            check("ready_after_done", 32'(rdy_hist[done_at + 1]), 1);
        end
    endtask

    always @(negedge clk) begin
        check("s_and_r_disjoint", 32'(bus.s_out & bus.r_out), 0);
`ifndef SR_BANK_INIT_CLEAR_EN
        check("single_cell_drive", 32'($countones(bus.s_out | bus.r_out) <= 1), 1);
`endif
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        // Test 1: reset release
`ifdef SR_BANK_INIT_CLEAR_EN
        check("t1_init_r_c1", 32'(bus.r_out), 32'hF);
        check("t1_init_rdy_c1", 32'(bus.in_ready), 0);
        @(negedge clk);
        check("t1_init_r_c2", 32'(bus.r_out), 32'hF);
        check("t1_init_busy_c2", 32'(bus.busy), 1);
        @(negedge clk);
        check("t1_init_gap_r", 32'(bus.r_out), 0);
        check("t1_init_gap_rdy", 32'(bus.in_ready), 0);
        @(negedge clk);
        check("t1_init_end_rdy", 32'(bus.in_ready), 1);
        check("t1_init_end_busy", 32'(bus.busy), 0);
`else
        check("t1_rdy", 32'(bus.in_ready), 1);
        check("t1_busy", 32'(bus.busy), 0);
        check("t1_done", 32'(bus.done), 0);
        check("t1_s", 32'(bus.s_out), 0);
        check("t1_r", 32'(bus.r_out), 0);
`endif
        check("t1_state", 32'(bus.state_q), 0);

        // Test 2: 0000 -> 0101
        run_word(4'b0101, 1'b0, 0);
        check("t2_latency", 32'(done_at), 11);
        check("t2_s_c1", 32'(s_hist[1]), 0);
        check("t2_s_c2", 32'(s_hist[2]), 4'b0001);
        check("t2_s_c3", 32'(s_hist[3]), 4'b0001);
        check("t2_s_c4", 32'(s_hist[4]), 0);
        check("t2_s_c7", 32'(s_hist[7]), 4'b0100);
        check("t2_s_c8", 32'(s_hist[8]), 4'b0100);
        check("t2_s_c9", 32'(s_hist[9]), 0);
        check("t2_r_never", 32'(r_or), 0);
        check("t2_stq_c3", 32'(st_hist[3]), 0);
        check("t2_stq_c4", 32'(st_hist[4]), 4'b0001);
        check("t2_busy_c10", 32'(busy_hist[10]), 1);
        check("t2_state", 32'(bus.state_q), 4'b0101);

        // Test 3: 0101 -> 0110
        run_word(4'b0110, 1'b0, 0);
        check("t3_latency", 32'(done_at), 11);
        check("t3_r_c2", 32'(r_hist[2]), 4'b0001);
        check("t3_r_c3", 32'(r_hist[3]), 4'b0001);
        check("t3_s_c6", 32'(s_hist[6]), 4'b0010);
        check("t3_s_c7", 32'(s_hist[7]), 4'b0010);
        check("t3_s_or", 32'(s_or), 4'b0010);
        check("t3_r_or", 32'(r_or), 4'b0001);
        check("t3_state", 32'(bus.state_q), 4'b0110);

        // Test 4: identical rewrite
        run_word(4'b0110, 1'b0, 0);
        check("t4_latency", 32'(done_at), 5);
        check("t4_no_s", 32'(s_or), 0);
        check("t4_no_r", 32'(r_or), 0);
        check("t4_state", 32'(bus.state_q), 4'b0110);

        // Test 5: in_valid held with changing data while busy
        run_word(4'b1001, 1'b1, 0);
        check("t5_latency", 32'(done_at), 17);
        check("t5_rdy_c1", 32'(rdy_hist[1]), 0);
        check("t5_s_or", 32'(s_or), 4'b1001);
        check("t5_r_or", 32'(r_or), 4'b0110);
        check("t5_state", 32'(bus.state_q), 4'b1001);
        @(negedge clk);
        check("t5_no_recapture", 32'(bus.busy), 0);

        // Test 6: reset during the s_out[2] pulse, then a clean write
        run_word(4'b0100, 1'b0, 7);
        check("t6_s_c7", 32'(s_hist[7]), 4'b0100);
        check("t6_stq_c7", 32'(st_hist[7]), 4'b1000);
        check("t6_s_after_rst", 32'(s_hist[8]), 0);
        check("t6_state_after_rst", 32'(st_hist[8]), 0);
        check("t6_done_after_rst", 32'(done_hist[8]), 0);
`ifdef SR_BANK_INIT_CLEAR_EN
        check("t6_r_after_rst", 32'(r_hist[8]), 32'hF);
        check("t6_busy_after_rst", 32'(busy_hist[8]), 1);
`else
        check("t6_r_after_rst", 32'(r_hist[8]), 0);
        check("t6_busy_after_rst", 32'(busy_hist[8]), 0);
        check("t6_rdy_after_rst", 32'(rdy_hist[8]), 1);
`endif
        run_word(4'b0100, 1'b0, 0);
        check("t6_latency", 32'(done_at), 8);
        check("t6_s_c4", 32'(s_hist[4]), 4'b0100);
        check("t6_s_c5", 32'(s_hist[5]), 4'b0100);
        check("t6_r_or", 32'(r_or), 0);
        check("t6_state", 32'(bus.state_q), 4'b0100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
